// File: rtl/zoom_pkg.sv
// zoom_pkg: definitions shared by the control unit and the zoom engines.
//   - instruction opcodes, default image geometry and memory widths
//   - engine FSM state encoding
//   - avg4(): 2x2 block average. Build option ZOOM_OUT_AVG_ROUND_EN selects
//     round-half-up; without it the average truncates.
package zoom_pkg;

    localparam int unsigned ORIGINAL_WIDTH  = 320;
    localparam int unsigned ORIGINAL_HEIGHT = 120;
    localparam int unsigned ADDR_W          = 16;
    localparam int unsigned DATA_W          = 16;
    localparam int unsigned PIX_W           = 8;

    // Destination region starts right after a 320x120 source image.
    localparam logic [ADDR_W-1:0] DST_BASE_DEFAULT = 16'd38400;

    typedef enum logic [2:0] {
        NOP,
        LOAD_IMG,
        ZOOM_IN_VD,
        ZOOM_IN_MP,
        ZOOM_OUT_MP,
        ZOOM_OUT_VD
    } zoom_opcode_t;

    typedef enum logic [1:0] {
        ZS_IDLE  = 2'd0,
        ZS_FETCH = 2'd1,
        ZS_WRITE = 2'd2,
        ZS_DONE  = 2'd3
    } zoom_state_t;

    // Sum of four pixels fits in PIX_W+2 bits; (1020 + 2) still fits,
    // so the rounded form never needs saturation.
    function automatic logic [PIX_W-1:0] avg4(input logic [PIX_W+1:0] sum);
        logic [PIX_W+1:0] t;
`ifdef ZOOM_OUT_AVG_ROUND_EN
        t = sum + (PIX_W+2)'(2);
`else
        t = sum;
`endif
        return t[PIX_W+1:2];
    endfunction

endpackage

// File: rtl/block_addr_gen.sv
// block_addr_gen: 2x2 block address walker for zoom_out_avg.
//   clock, reset_n    : clock, asynchronous active-low reset
//   load              : load pointers from src_base/dst_base, ox = oy = 0
//   step              : advance to the next block in raster order
//   a0..a3            : source addresses of the current block (TL, TR, BL, BR)
//   dst_ptr           : destination address of the current block
//   last_block        : current block is the bottom-right one
module block_addr_gen #(
    parameter int unsigned SRC_WIDTH  = 320,
    parameter int unsigned SRC_HEIGHT = 120,
    parameter int unsigned ADDR_W     = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              load,
    input  logic              step,
    input  logic [ADDR_W-1:0] src_base,
    input  logic [ADDR_W-1:0] dst_base,
    output logic [ADDR_W-1:0] a0,
    output logic [ADDR_W-1:0] a1,
    output logic [ADDR_W-1:0] a2,
    output logic [ADDR_W-1:0] a3,
    output logic [ADDR_W-1:0] dst_ptr,
    output logic              last_block
);

    localparam int unsigned DST_W = SRC_WIDTH / 2;
    localparam int unsigned DST_H = SRC_HEIGHT / 2;
    localparam int unsigned OX_W  = (DST_W > 1) ? $clog2(DST_W) : 1;
    localparam int unsigned OY_W  = (DST_H > 1) ? $clog2(DST_H) : 1;

    localparam logic [OX_W-1:0]   OX_LAST     = OX_W'(DST_W - 1);
    localparam logic [OY_W-1:0]   OY_LAST     = OY_W'(DST_H - 1);
    localparam logic [ADDR_W-1:0] ROW_STRIDE  = ADDR_W'(SRC_WIDTH);
    localparam logic [ADDR_W-1:0] PAIR_STRIDE = ADDR_W'(2 * SRC_WIDTH);

    logic [ADDR_W-1:0] row_ptr;
    logic [OX_W-1:0]   ox;
    logic [OY_W-1:0]   oy;

    always_comb begin
        a0         = row_ptr + ADDR_W'({ox, 1'b0});
        a1         = a0 + ADDR_W'(1);
        a2         = a0 + ROW_STRIDE;
        a3         = a2 + ADDR_W'(1);
        last_block = (ox == OX_LAST) && (oy == OY_LAST);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            row_ptr <= '0;
            dst_ptr <= '0;
            ox      <= '0;
            oy      <= '0;
        end else if (load) begin
            row_ptr <= src_base;
            dst_ptr <= dst_base;
            ox      <= '0;
            oy      <= '0;
        end else if (step) begin
            dst_ptr <= dst_ptr + ADDR_W'(1);
            if (ox == OX_LAST) begin
                ox      <= '0;
                oy      <= oy + OY_W'(1);
                row_ptr <= row_ptr + PAIR_STRIDE;
            end else begin
                ox <= ox + OX_W'(1);
            end
        end
    end

endmodule

// File: rtl/zoom_out_avg.sv
// zoom_out_avg: 2x2 block-averaging downscaler (ZOOM_OUT_MP).
// Reads every 2x2 block of the source image and writes one averaged pixel
// per block, raster order, 6 cycles per output pixel.
//   clock, reset_n     : clock, asynchronous active-low reset
//   start              : one-cycle request, accepted in IDLE only
//   src_base, dst_base : source/destination (0,0) word addresses
//   mem_addr, mem_wr   : memory address and write enable
//   mem_data_out       : write data {8'h00, avg}
//   mem_q              : synchronous read data (1-cycle latency)
//   busy, done         : engine active / one-cycle completion pulse
// Build option: ZOOM_OUT_AVG_ROUND_EN selects round-half-up averaging.
module zoom_out_avg
    import zoom_pkg::zoom_state_t, zoom_pkg::ZS_IDLE, zoom_pkg::ZS_FETCH,
           zoom_pkg::ZS_WRITE, zoom_pkg::ZS_DONE, zoom_pkg::PIX_W, zoom_pkg::avg4;
#(
    parameter int unsigned SRC_WIDTH  = zoom_pkg::ORIGINAL_WIDTH,
    parameter int unsigned SRC_HEIGHT = zoom_pkg::ORIGINAL_HEIGHT,
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned DATA_W     = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_base,
    input  logic [ADDR_W-1:0] dst_base,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_data_out,
    input  logic [DATA_W-1:0] mem_q,
    output logic              busy,
    output logic              done
);

    if ((SRC_WIDTH % 2) != 0 || (SRC_HEIGHT % 2) != 0 || SRC_WIDTH == 0 || SRC_HEIGHT == 0)
    begin : g_bad_geometry
        $error("zoom_out_avg: SRC_WIDTH and SRC_HEIGHT must be even and non-zero");
    end

    zoom_state_t       state;
    logic [2:0]        phase;
    logic [PIX_W+1:0]  acc;
    logic [PIX_W+1:0]  sum;
    logic              last_q;
    logic              load;
    logic              step;
    logic              unused_hi;

    logic [ADDR_W-1:0] a0, a1, a2, a3, dst_ptr;
    logic              last_block;

    always_comb begin
        sum       = acc + {2'b00, mem_q[PIX_W-1:0]};
        load      = (state == ZS_IDLE) && start;
        step      = (state == ZS_FETCH) && (phase == 3'd4);
        unused_hi = ^mem_q[DATA_W-1:PIX_W];
    end

    block_addr_gen #(
        .SRC_WIDTH  (SRC_WIDTH),
        .SRC_HEIGHT (SRC_HEIGHT),
        .ADDR_W     (ADDR_W)
    ) u_addr_gen (
        .clock      (clock),
        .reset_n    (reset_n),
        .load       (load),
        .step       (step),
        .src_base   (src_base),
        .dst_base   (dst_base),
        .a0         (a0),
        .a1         (a1),
        .a2         (a2),
        .a3         (a3),
        .dst_ptr    (dst_ptr),
        .last_block (last_block)
    );

    // Outputs are registered one cycle ahead of the state they belong to.
    // The walker steps on the edge entering WRITE, so the destination
    // address and last-block flag are captured from their pre-step values
    // there, and the next block's a0 is already valid when WRITE ends.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ZS_IDLE;
            phase        <= '0;
            acc          <= '0;
            last_q       <= 1'b0;
            mem_addr     <= '0;
            mem_wr       <= 1'b0;
            mem_data_out <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            case (state)
                ZS_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state    <= ZS_FETCH;
                        phase    <= '0;
                        busy     <= 1'b1;
                        mem_addr <= src_base;
                    end
                end
                ZS_FETCH: begin
                    phase <= phase + 3'd1;
                    if (phase == 3'd0) acc <= '0;
                    else               acc <= sum;
                    case (phase)
                        3'd0:    mem_addr <= a1;
                        3'd1:    mem_addr <= a2;
                        3'd2:    mem_addr <= a3;
                        default: ;
                    endcase
                    if (phase == 3'd4) begin
                        state        <= ZS_WRITE;
                        last_q       <= last_block;
                        mem_addr     <= dst_ptr;
                        mem_wr       <= 1'b1;
                        mem_data_out <= DATA_W'(avg4(sum));
                    end
                end
                ZS_WRITE: begin
                    mem_wr       <= 1'b0;
                    mem_data_out <= '0;
                    if (last_q) begin
                        state <= ZS_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        state    <= ZS_FETCH;
                        phase    <= '0;
                        mem_addr <= a0;
                    end
                end
                ZS_DONE: begin
                    done  <= 1'b0;
                    state <= ZS_IDLE;
                end
                default: state <= ZS_IDLE;
            endcase
        end
    end

endmodule
